hps_dma_arbiter: RTL and testbench

Shares the single HPS DMA channel of `hps_io` between two core-side memory requesters, e.g. disk sector buffer and BIOS/option ROM loader. Picks a requester round-robin, advertises it on `dma_req` for HPS command 0x63, and tracks the HPS start/finish/abort codes on `dma_status`. While a transfer is active it routes the HPS word reads and writes to the granted requester's memory port, and drives the read-wait handshake back to `hps_io`.

---
 rtl/hps_dma_arbiter_if.sv | 37 +++
 rtl/hps_dma_arbiter.sv | 171 +++++++++++++++++
 tb/tb_hps_dma_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_dma_arbiter_if.sv
// Signal bundle between hps_dma_arbiter, the hps_io DMA channel and the two requester memory ports.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface hps_dma_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        err;
    logic [1:0]  dma_req;
    logic [1:0]  dma_status;
    logic        dma_rd;
    logic        dma_wr;
    logic [31:0] dma_addr;
    logic [31:0] dma_dout;
    logic [31:0] dma_din;
    logic        dma_wait;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_rd;
    logic [1:0]  mem_wr;
    logic [31:0] mem_rdata0;
    logic [31:0] mem_rdata1;
    logic [1:0]  mem_ready;

    modport master (
        input  req, dma_status, dma_rd, dma_wr, dma_addr, dma_dout,
               mem_rdata0, mem_rdata1, mem_ready,
        output grant, done, err, dma_req, dma_din, dma_wait,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output req, dma_status, dma_rd, dma_wr, dma_addr, dma_dout,
               mem_rdata0, mem_rdata1, mem_ready,
        input  grant, done, err, dma_req, dma_din, dma_wait,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/hps_dma_arbiter.sv
// Round-robin sharing of the single hps_io DMA channel between two memory requesters,
// including word read/write routing and the ioctl_wait handshake back to hps_io.
module hps_dma_arbiter #(
    parameter logic [23:0] OFFER_TO = 24'd10_000_000
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    hps_dma_arbiter_if.master io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_ACTIVE, S_DONE} state_t;

    state_t      r_state;
    logic        r_gidx;
    logic        r_last;
    logic [23:0] r_cnt;
    logic        r_busy;
    logic        r_pend_fin;
    logic        r_pend_abt;
    logic [1:0]  r_grant;
    logic [1:0]  r_dma_req;
    logic [1:0]  r_done;
    logic        r_err;
    logic        r_wait;
    logic [31:0] r_din;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [1:0]  r_mem_rd;
    logic [1:0]  r_mem_wr;

    logic        w_pick;
    logic        w_start;
    logic        w_fin;
    logic        w_abt;
    logic        w_ready;
    logic        w_end;
    logic        w_end_err;
    logic        w_live;
    logic [1:0]  w_onehot;
    logic [1:0]  w_pick_onehot;
    logic [23:0] w_cnt_next;
    logic [31:0] w_rdata;

    // A finish/abort behind an outstanding read only takes effect once the read data returns.
    always_comb begin
        w_pick        = (io_bus.req == 2'b11) ? ~r_last : io_bus.req[1];
        w_pick_onehot = w_pick ? 2'b10 : 2'b01;
        w_start       = (io_bus.dma_status == 2'b01);
        w_fin         = (io_bus.dma_status == 2'b10);
        w_abt         = (io_bus.dma_status == 2'b11);
        w_ready       = io_bus.mem_ready[r_gidx];
        w_rdata       = r_gidx ? io_bus.mem_rdata1 : io_bus.mem_rdata0;
        w_onehot      = r_gidx ? 2'b10 : 2'b01;
        w_cnt_next    = r_cnt + 24'd1;
        w_end         = (r_state == S_ACTIVE) &&
                        (w_fin || w_abt || r_pend_fin || r_pend_abt) &&
                        (!r_busy || w_ready);
        w_end_err     = w_abt || r_pend_abt;
        w_live        = (r_state == S_ACTIVE) && !w_end;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gidx      <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= 24'd0;
            r_busy      <= 1'b0;
            r_pend_fin  <= 1'b0;
            r_pend_abt  <= 1'b0;
            r_grant     <= 2'b00;
            r_dma_req   <= 2'b00;
            r_done      <= 2'b00;
            r_err       <= 1'b0;
            r_wait      <= 1'b0;
            r_din       <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_rd    <= 2'b00;
            r_mem_wr    <= 2'b00;
        end else begin
            r_done   <= 2'b00;
            r_err    <= 1'b0;
            r_mem_rd <= 2'b00;
            r_mem_wr <= 2'b00;

            case (r_state)
                S_IDLE: begin
                    if (|io_bus.req) begin
                        r_gidx    <= w_pick;
                        r_last    <= w_pick;
                        r_grant   <= w_pick_onehot;
                        r_dma_req <= w_pick_onehot;
                        r_cnt     <= 24'd0;
                        r_state   <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    r_cnt <= w_cnt_next;
                    if (w_start) begin
                        r_state <= S_ACTIVE;
                    end else if (w_abt || (w_cnt_next >= OFFER_TO)) begin
                        r_state   <= S_DONE;
                        r_done    <= w_onehot;
                        r_err     <= 1'b1;
                        r_grant   <= 2'b00;
                        r_dma_req <= 2'b00;
                    end else if (!io_bus.req[r_gidx]) begin
                        r_state   <= S_IDLE;
                        r_grant   <= 2'b00;
                        r_dma_req <= 2'b00;
                    end
                end
                S_ACTIVE: begin
                    if (w_end) begin
                        r_state    <= S_DONE;
                        r_done     <= w_onehot;
                        r_err      <= w_end_err;
                        r_grant    <= 2'b00;
                        r_dma_req  <= 2'b00;
                        r_pend_fin <= 1'b0;
                        r_pend_abt <= 1'b0;
                    end else if (r_busy) begin
                        r_pend_fin <= r_pend_fin | w_fin;
                        r_pend_abt <= r_pend_abt | w_abt;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Reads outside a live transfer still get one wait cycle so hps_io's edge capture fires.
            if (r_wait) begin
                if (!r_busy) begin
                    r_wait <= 1'b0;
                end else if (w_ready) begin
                    r_din  <= w_rdata;
                    r_wait <= 1'b0;
                    r_busy <= 1'b0;
                end
            end else if (io_bus.dma_rd) begin
                r_wait <= 1'b1;
                if (w_live) begin
                    r_mem_addr <= io_bus.dma_addr;
                    r_mem_rd   <= w_onehot;
                    r_busy     <= 1'b1;
                end else begin
                    r_din <= 32'hFFFF_FFFF;
                end
            end else if (io_bus.dma_wr && w_live) begin
                r_mem_addr  <= io_bus.dma_addr;
                r_mem_wdata <= io_bus.dma_dout;
                r_mem_wr    <= w_onehot;
            end
        end
    end

    assign io_bus.grant     = r_grant;
    assign io_bus.dma_req   = r_dma_req;
    assign io_bus.done      = r_done;
    assign io_bus.err       = r_err;
    assign io_bus.dma_din   = r_din;
    assign io_bus.dma_wait  = r_wait;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.mem_rd    = r_mem_rd;
    assign io_bus.mem_wr    = r_mem_wr;
endmodule

// File: tb/tb_hps_dma_arbiter.sv
// Bench for hps_dma_arbiter: directed scenarios with literal expectations, then randomized
// HPS/requester traffic compared every cycle against a transaction-level model.
module tb_hps_dma_arbiter;
    localparam logic [23:0] OFFER_TO = 24'd16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmpOn = 1'b0;
    bit   autoRespond = 1'b0;

    hps_dma_arbiter_if bus();

    hps_dma_arbiter #(.OFFER_TO(OFFER_TO)) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearPulses();
        bus.dma_status = 2'b00;
        bus.dma_rd     = 1'b0;
        bus.dma_wr     = 1'b0;
        if (!autoRespond) bus.mem_ready = 2'b00;
    endtask

    task automatic resetPulse();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_wait", {31'd0, bus.dma_wait}, 32'd0);
        checkOutput("async_rst_grant", {30'd0, bus.grant}, 32'd0);
        checkOutput("async_rst_dma_req", {30'd0, bus.dma_req}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [1:0] oneHot(int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    // Transaction-level model: ownership, offer age, outstanding read and deferred end status.
    typedef enum int {M_IDLE, M_OFFER, M_ACTIVE, M_DONE} mode_t;
    mode_t       mMode = M_IDLE;
    int          mOwner = 0;
    int          mLast = 1;
    int          mOfferAge = 0;
    bit          mReadOut = 1'b0;
    bit          mFinishSeen = 1'b0;
    bit          mAbortSeen = 1'b0;
    bit          mDoneErr = 1'b0;
    logic        eWait = 1'b0;
    logic [31:0] eDin = 32'd0;
    logic [31:0] eMemAddr = 32'd0;
    logic [31:0] eMemWdata = 32'd0;
    logic [1:0]  eMemRd = 2'b00;
    logic [1:0]  eMemWr = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mMode = M_IDLE; mOwner = 0; mLast = 1; mOfferAge = 0;
            mReadOut = 0; mFinishSeen = 0; mAbortSeen = 0; mDoneErr = 0;
            eWait = 0; eDin = 0; eMemAddr = 0; eMemWdata = 0; eMemRd = 0; eMemWr = 0;
        end else begin
            mode_t      pre;
            logic [1:0] st;
            bit         ending;
            pre    = mMode;
            st     = bus.dma_status;
            eMemRd = 2'b00;
            eMemWr = 2'b00;
            ending = (pre == M_ACTIVE) && (st >= 2'd2 || mFinishSeen || mAbortSeen) &&
                     (!mReadOut || bus.mem_ready[mOwner]);
            if (eWait) begin
                if (mReadOut && bus.mem_ready[mOwner]) begin
                    eDin = (mOwner == 1) ? bus.mem_rdata1 : bus.mem_rdata0;
                    eWait = 0;
                    mReadOut = 0;
                end else if (!mReadOut) begin
                    eWait = 0;
                end
            end else if (bus.dma_rd) begin
                eWait = 1;
                if (pre == M_ACTIVE && !ending) begin
                    eMemAddr = bus.dma_addr;
                    eMemRd = oneHot(mOwner);
                    mReadOut = 1;
                end else begin
                    eDin = 32'hFFFF_FFFF;
                end
            end else if (bus.dma_wr && pre == M_ACTIVE && !ending) begin
                eMemAddr = bus.dma_addr;
                eMemWdata = bus.dma_dout;
                eMemWr = oneHot(mOwner);
            end
            case (pre)
                M_IDLE: if (bus.req != 2'b00) begin
                    mOwner = (bus.req == 2'b11) ? 1 - mLast : (bus.req[1] ? 1 : 0);
                    mLast = mOwner;
                    mOfferAge = 0;
                    mMode = M_OFFER;
                end
                M_OFFER: begin
                    mOfferAge++;
                    if (st == 2'b01) mMode = M_ACTIVE;
                    else if (st == 2'b11 || mOfferAge >= int'(OFFER_TO)) begin
                        mMode = M_DONE;
                        mDoneErr = 1;
                    end else if (!bus.req[mOwner]) mMode = M_IDLE;
                end
                M_ACTIVE: begin
                    if (ending) begin
                        mMode = M_DONE;
                        mDoneErr = (st == 2'b11) || mAbortSeen;
                        mFinishSeen = 0;
                        mAbortSeen = 0;
                    end else begin
                        if (st == 2'b10) mFinishSeen = 1;
                        if (st == 2'b11) mAbortSeen = 1;
                    end
                end
                default: mMode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmpOn) begin
            logic [1:0] expGrant;
            expGrant = (mMode == M_OFFER || mMode == M_ACTIVE) ? oneHot(mOwner) : 2'b00;
            checkOutput("grant", {30'd0, bus.grant}, {30'd0, expGrant});
            checkOutput("dma_req", {30'd0, bus.dma_req}, {30'd0, expGrant});
            checkOutput("done", {30'd0, bus.done}, {30'd0, (mMode == M_DONE) ? oneHot(mOwner) : 2'b00});
            checkOutput("err", {31'd0, bus.err}, {31'd0, mMode == M_DONE && mDoneErr});
            checkOutput("dma_din", bus.dma_din, eDin);
            checkOutput("dma_wait", {31'd0, bus.dma_wait}, {31'd0, eWait});
            checkOutput("mem_addr", bus.mem_addr, eMemAddr);
            checkOutput("mem_wdata", bus.mem_wdata, eMemWdata);
            checkOutput("mem_rd", {30'd0, bus.mem_rd}, {30'd0, eMemRd});
            checkOutput("mem_wr", {30'd0, bus.mem_wr}, {30'd0, eMemWr});
        end
    end

    // Memory side: answers each mem_rd after 0..4 cycles, with occasional stray ready pulses.
    bit         respPending = 0;
    int         respDelay = 0;
    logic [1:0] respBit = 2'b00;
    always @(posedge clk) begin
        #2;
        if (autoRespond) begin
            bus.mem_ready  = 2'b00;
            bus.mem_rdata0 = $urandom;
            bus.mem_rdata1 = $urandom;
            if (bus.mem_rd != 2'b00) begin
                respPending = 1;
                respBit = bus.mem_rd;
                respDelay = $urandom_range(0, 4);
            end
            if (respPending) begin
                if (respDelay == 0) begin
                    bus.mem_ready = respBit;
                    respPending = 0;
                end else respDelay--;
            end
            if ($urandom_range(0, 99) < 3) bus.mem_ready = bus.mem_ready | 2'($urandom_range(1, 2));
        end
    end

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            int r;
            logic [31:0] a;
            clearPulses();
            r = $urandom_range(0, 99);
            if (r < 6) bus.req = 2'($urandom_range(0, 3));
            else if (r < 14) bus.dma_status = 2'($urandom_range(1, 3));
            else if (r < 34) begin
                a = $urandom;
                bus.dma_addr = a & 32'hFFFF_FFFC;
                bus.dma_dout = $urandom;
                if ($urandom_range(0, 1) == 1) bus.dma_rd = 1'b1;
                else bus.dma_wr = 1'b1;
            end else if (r == 99 && $urandom_range(0, 4) == 0) begin
                resetPulse();
                continue;
            end
            tick();
        end
        clearPulses();
    endtask

    initial begin
        logic [1:0] expReq [3];
        expReq[0] = 2'b01; expReq[1] = 2'b10; expReq[2] = 2'b01;
        bus.req = 0; bus.dma_status = 0; bus.dma_rd = 0; bus.dma_wr = 0;
        bus.dma_addr = 0; bus.dma_dout = 0; bus.mem_rdata0 = 0; bus.mem_rdata1 = 0; bus.mem_ready = 0;
        #1 rst_n = 1'b0;
        cmpOn = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        checkOutput("rst_grant", {30'd0, bus.grant}, 32'd0);
        checkOutput("rst_din", bus.dma_din, 32'd0);
        checkOutput("rst_wait", {31'd0, bus.dma_wait}, 32'd0);
        bus.req = 2'b01;
        tick();
        checkOutput("t1_dma_req", {30'd0, bus.dma_req}, 32'd1);
        bus.dma_status = 2'b01; tick();
        bus.dma_status = 2'b10; bus.req = 2'b00; tick();
        bus.dma_status = 2'b00;
        checkOutput("t1_done", {30'd0, bus.done}, 32'd1);
        checkOutput("t1_err", {31'd0, bus.err}, 32'd0);
        checkOutput("t1_dma_req_idle", {30'd0, bus.dma_req}, 32'd0);
        tick();
        checkOutput("t1_done_off", {30'd0, bus.done}, 32'd0);

        resetPulse();
        bus.req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t2_dma_req", {30'd0, bus.dma_req}, {30'd0, expReq[k]});
            bus.dma_status = 2'b01; tick();
            bus.dma_status = 2'b10; tick();
            bus.dma_status = 2'b00;
            checkOutput("t2_done", {30'd0, bus.done}, {30'd0, expReq[k]});
            tick();
        end
        bus.req = 2'b00;
        tick();

        bus.req = 2'b10; tick();
        bus.dma_status = 2'b01; tick();
        bus.dma_status = 2'b00;
        bus.dma_wr = 1'b1; bus.dma_addr = 32'h100; bus.dma_dout = 32'hDEADBEEF; tick();
        bus.dma_wr = 1'b0;
        checkOutput("t3_mem_wr", {30'd0, bus.mem_wr}, 32'd2);
        checkOutput("t3_mem_addr", bus.mem_addr, 32'h100);
        checkOutput("t3_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        bus.dma_rd = 1'b1; bus.dma_addr = 32'h104; tick();
        bus.dma_rd = 1'b0;
        checkOutput("t3_mem_rd", {30'd0, bus.mem_rd}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_wait_high", {31'd0, bus.dma_wait}, 32'd1);
            tick();
        end
        checkOutput("t3_wait_high", {31'd0, bus.dma_wait}, 32'd1);
        bus.mem_ready = 2'b10; bus.mem_rdata1 = 32'h12345678; tick();
        bus.mem_ready = 2'b00;
        checkOutput("t3_wait_low", {31'd0, bus.dma_wait}, 32'd0);
        checkOutput("t3_din", bus.dma_din, 32'h12345678);
        bus.req = 2'b00; bus.dma_status = 2'b10; tick();
        bus.dma_status = 2'b00;
        checkOutput("t3_done", {30'd0, bus.done}, 32'd2);
        tick();

        bus.dma_rd = 1'b1; tick();
        bus.dma_rd = 1'b0;
        checkOutput("t4_din_ff", bus.dma_din, 32'hFFFF_FFFF);
        checkOutput("t4_wait", {31'd0, bus.dma_wait}, 32'd1);
        checkOutput("t4_mem_rd", {30'd0, bus.mem_rd}, 32'd0);
        tick();
        checkOutput("t4_wait_drop", {31'd0, bus.dma_wait}, 32'd0);
        bus.req = 2'b01; tick();
        checkOutput("t4_offer", {30'd0, bus.dma_req}, 32'd1);
        for (int i = 0; i < int'(OFFER_TO) - 1; i++) begin
            tick();
            checkOutput("t4_still_offer", {30'd0, bus.dma_req}, 32'd1);
        end
        tick();
        checkOutput("t4_to_done", {30'd0, bus.done}, 32'd1);
        checkOutput("t4_to_err", {31'd0, bus.err}, 32'd1);
        bus.req = 2'b00; tick();

        bus.req = 2'b01; tick();
        bus.dma_status = 2'b01; tick();
        bus.dma_status = 2'b00; bus.req = 2'b00;
        bus.dma_rd = 1'b1; bus.dma_addr = 32'h200; tick();
        bus.dma_rd = 1'b0;
        bus.dma_status = 2'b11; tick();
        bus.dma_status = 2'b00;
        checkOutput("t5_deferred", {30'd0, bus.done}, 32'd0);
        checkOutput("t5_grant_held", {30'd0, bus.grant}, 32'd1);
        tick();
        checkOutput("t5_deferred2", {30'd0, bus.done}, 32'd0);
        bus.mem_ready = 2'b01; bus.mem_rdata0 = 32'hCAFEF00D; tick();
        bus.mem_ready = 2'b00;
        checkOutput("t5_done", {30'd0, bus.done}, 32'd1);
        checkOutput("t5_err", {31'd0, bus.err}, 32'd1);
        checkOutput("t5_din", bus.dma_din, 32'hCAFEF00D);
        tick();
        bus.req = 2'b01; tick();
        bus.req = 2'b00; tick();
        checkOutput("t5_drop_grant", {30'd0, bus.grant}, 32'd0);
        checkOutput("t5_drop_done", {30'd0, bus.done}, 32'd0);
        tick();
        checkOutput("t5_drop_done2", {30'd0, bus.done}, 32'd0);

        bus.req = 2'b10; tick();
        bus.dma_status = 2'b01; tick();
        bus.dma_status = 2'b00; bus.req = 2'b00;
        bus.dma_rd = 1'b1; bus.dma_addr = 32'h300; tick();
        bus.dma_rd = 1'b0;
        checkOutput("t6_wait", {31'd0, bus.dma_wait}, 32'd1);
        resetPulse();
        bus.mem_ready = 2'b10; bus.mem_rdata1 = 32'h55555555; tick();
        bus.mem_ready = 2'b00;
        checkOutput("t6_late_din", bus.dma_din, 32'd0);
        checkOutput("t6_late_wait", {31'd0, bus.dma_wait}, 32'd0);
        tick();

        autoRespond = 1'b1;
        applyStimulus(4000);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
